// File: rtl/tomasulo_instr_queue_pkg.sv
// Shared constants for the tomasulo front end: instruction width, issue
// width, queue sizing defaults and opcode encodings.
package tomasulo_instr_queue_pkg;

  localparam int INSTR_W     = 16;
  localparam int IQ_ISSUE_W  = 2;
  localparam int IQ_DEPTH    = 8;
  localparam int IQ_AF_LEVEL = 6;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_MUL  = 4'h3;
  localparam logic [OPC_W-1:0] OPC_DIV  = 4'h4;
  localparam logic [OPC_W-1:0] OPC_LD   = 4'h5;
  localparam logic [OPC_W-1:0] OPC_ST   = 4'h6;
  localparam logic [OPC_W-1:0] OPC_BR   = 4'h7;

  // Extracts the opcode field, which occupies the top bits of a word.
  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/tomasulo_instr_queue_ring_mem.sv
// Ring storage for the instruction queue: one synchronous write port and
// ISSUE_W asynchronous read ports at consecutive addresses from rd_base.
module tomasulo_instr_queue_ring_mem #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2
) (
  input  logic                        clock,
  input  logic                        wr_en,
  input  logic [$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]    rd_base,
  output logic [ISSUE_W*DATA_W-1:0]   rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read addresses wrap naturally through the pointer width.
  for (genvar i = 0; i < ISSUE_W; i++) begin : g_rd
    assign rd_data[i*DATA_W +: DATA_W] = mem[rd_base + AW'(i)];
  end

endmodule

// File: rtl/tomasulo_instr_queue.sv
// In-order instruction queue feeding the tomasulo issue stage: single-word
// push, 0..ISSUE_W pop per cycle, flush, occupancy flags and sticky errors.
module tomasulo_instr_queue
  import tomasulo_instr_queue_pkg::*;
#(
  parameter int DATA_W   = INSTR_W,
  parameter int DEPTH    = IQ_DEPTH,
  parameter int ISSUE_W  = IQ_ISSUE_W,
  parameter int AF_LEVEL = IQ_AF_LEVEL
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push_valid,
  input  logic [DATA_W-1:0]              push_data,
  output logic                           push_ready,
  input  logic [$clog2(ISSUE_W+1)-1:0]   pop_count,
  output logic [ISSUE_W*DATA_W-1:0]      head_data,
  output logic [ISSUE_W-1:0]             head_valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(ISSUE_W+1);

  logic [AW-1:0]             rd_ptr, wr_ptr;
  logic [PW-1:0]             pop_clamped;
  logic [CW-1:0]             pop_req, pop_n;
  logic                      pop_err;
  logic                      push_acc;
  logic [ISSUE_W*DATA_W-1:0] rd_data;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign push_ready  = !full;
  assign push_acc    = push_valid && push_ready;

  // Clamp the pop request to ISSUE_W, then to the live entries; either clamp is an error.
  always_comb begin
    pop_clamped = (pop_count > PW'(ISSUE_W)) ? PW'(ISSUE_W) : pop_count;
    pop_req     = CW'(pop_clamped);
    pop_n       = (pop_req > count) ? count : pop_req;
    pop_err     = (pop_count > PW'(ISSUE_W)) || (pop_req > count);
  end

  // Pointer, occupancy and sticky-flag state; flush drops entries but keeps the flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_acc) - pop_n;
      if (push_valid && full) overflow <= 1'b1;
      if (pop_err) underflow <= 1'b1;
    end
  end

  tomasulo_instr_queue_ring_mem #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ISSUE_W (ISSUE_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push_acc && !flush && !reset),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_base (rd_ptr),
    .rd_data (rd_data)
  );

  // Head slots in program order; slots beyond the occupancy drive zero.
  always_comb begin
    head_valid = '0;
    head_data  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (CW'(i) < count) begin
        head_valid[i]                 = 1'b1;
        head_data[i*DATA_W +: DATA_W] = rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_instr_queue.sv
// Self-checking bench for tomasulo_instr_queue (DATA_W=16, DEPTH=8,
// ISSUE_W=2, AF_LEVEL=6). A queue-based reference holds the expected
// words; each cycle the head view, count and flags are compared with it,
// alongside hand-computed expectations from a vector table and sequences.
module tb_tomasulo_instr_queue;
  import tomasulo_instr_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, push_valid;
  logic [15:0] push_data;
  logic [1:0]  pop_count;
  logic        push_ready, full, empty, almost_full, overflow, underflow;
  logic [31:0] head_data;
  logic [1:0]  head_valid;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  logic [15:0] mq[$];
  logic        m_over = 1'b0;
  logic        m_under = 1'b0;

  always #5 clk = ~clk;

  tomasulo_instr_queue #(
    .DATA_W(16), .DEPTH(8), .ISSUE_W(2), .AF_LEVEL(6)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .flush       (flush),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .pop_count   (pop_count),
    .head_data   (head_data),
    .head_valid  (head_valid),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference update, using the state before the edge.
  task automatic model_update(input logic rs, input logic fl, input logic pv,
                              input logic [15:0] pd, input logic [1:0] pc);
    int n;
    int req;
    bit was_full;
    if (rs) begin
      mq.delete();
      m_over  = 1'b0;
      m_under = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == 8);
      if (pv && was_full) m_over = 1'b1;
      req = (pc > 2) ? 2 : int'(pc);
      if (pc > 2 || int'(pc) > mq.size()) m_under = 1'b1;
      n = (req > mq.size()) ? mq.size() : req;
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (pv && !was_full) mq.push_back(pd);
    end
  endtask

  task automatic check_model();
    logic [15:0] e0, e1;
    e0 = (mq.size() > 0) ? mq[0] : 16'h0;
    e1 = (mq.size() > 1) ? mq[1] : 16'h0;
    chk("count",       32'(count),       32'(mq.size()));
    chk("empty",       32'(empty),       32'(mq.size() == 0));
    chk("full",        32'(full),        32'(mq.size() == 8));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 6));
    chk("push_ready",  32'(push_ready),  32'(mq.size() != 8));
    chk("overflow",    32'(overflow),    32'(m_over));
    chk("underflow",   32'(underflow),   32'(m_under));
    chk("head_valid",  32'(head_valid),  {30'd0, mq.size() > 1, mq.size() > 0});
    chk("head_data",   head_data,        {e1, e0});
  endtask

  task automatic step(input logic rs, input logic fl, input logic pv,
                      input logic [15:0] pd, input logic [1:0] pc);
    reset = rs; flush = fl; push_valid = pv; push_data = pd; pop_count = pc;
    @(posedge clk);
    model_update(rs, fl, pv, pd, pc);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rs, fl, pv;
    logic [15:0] pd;
    logic [1:0]  pc;
    logic [3:0]  e_cnt;
    logic [1:0]  e_hv;
    logic [31:0] e_head;
    logic        e_uf;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [15:0] w;
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_count = '0;

    //        rs    fl    pv    pd        pc    cnt  hv     head            uf
    vt[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd0, 2'b00, 32'h0000_0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd0, 2'b00, 32'h0000_0000, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'h1111, 2'd0, 4'd1, 2'b01, 32'h0000_1111, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 16'h2222, 2'd0, 4'd2, 2'b11, 32'h2222_1111, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd2, 2'b11, 32'h2222_1111, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 16'h3333, 2'd1, 4'd2, 2'b11, 32'h3333_2222, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 4'd1, 2'b01, 32'h0000_3333, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd2, 4'd0, 2'b00, 32'h0000_0000, 1'b1};
    vt[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 4'd0, 2'b00, 32'h0000_0000, 1'b0};

    foreach (vt[i]) begin
      step(vt[i].rs, vt[i].fl, vt[i].pv, vt[i].pd, vt[i].pc);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_hv", i),    32'(head_valid), 32'(vt[i].e_hv));
      chk($sformatf("vec%0d_head", i),  head_data, vt[i].e_head);
      chk($sformatf("vec%0d_uf", i),    32'(underflow), 32'(vt[i].e_uf));
    end

    // Fill to full, overflow, then pop while full with a refused push.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'hA000 + 16'(i), 2'd0);
      if (i == 5) chk("af_at_6", 32'(almost_full), 32'd1);
      if (i == 4) chk("af_at_5", 32'(almost_full), 32'd0);
    end
    chk("full_at_8", 32'(full), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'hDEAD, 2'd0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(count), 32'd8);
    step(1'b0, 1'b0, 1'b1, 16'hBEEF, 2'd2);
    chk("full_pop_cnt", 32'(count), 32'd6);
    chk("full_pop_head", head_data, 32'hA003_A002);
    step(1'b0, 1'b0, 1'b1, 16'hC0DE, 2'd0);
    chk("after_full_push", 32'(count), 32'd7);

    // Oversized pop request: pops two and flags underflow.
    step(1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'hB000 + 16'(i), 2'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 2'd3);
    chk("pop3_cnt", 32'(count), 32'd3);
    chk("pop3_uf", 32'(underflow), 32'd1);
    chk("pop3_head", head_data, 32'hB003_B002);

    // Wrap-around: steady state push+pop at Count=1 for 20 cycles.
    step(1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 16'h5000, 2'd0);
    for (int i = 1; i <= 20; i++) begin
      w = 16'h5000 + 16'(i);
      step(1'b0, 1'b0, 1'b1, w, 2'd1);
      chk("wrap_cnt", 32'(count), 32'd1);
      chk("wrap_head0", 32'(head_data[15:0]), 32'(w));
    end

    // Underflow from Count=1, then flush with a push pending.
    step(1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 16'h6000, 2'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 2'd2);
    chk("uf_empty", 32'(empty), 32'd1);
    chk("uf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'h7000 + 16'(i), 2'd0);
    chk("pre_flush_cnt", 32'(count), 32'd5);
    step(1'b0, 1'b1, 1'b1, 16'h7777, 2'd1);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_uf_kept", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h7100, 2'd0);
    chk("post_flush_head", head_data, 32'h0000_7100);

    // Reset in the middle of a push at Count=4 with both flags set.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 16'h8000 + 16'(i), 2'd0);
    step(1'b0, 1'b0, 1'b1, 16'h8F00, 2'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 2'd2);
    step(1'b0, 1'b0, 1'b0, 16'h0, 2'd2);
    chk("pre_rst_cnt", 32'(count), 32'd4);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 1'b1, 16'h9999, 2'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_hv", 32'(head_valid), 32'd0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
